// File: rtl/jelly3_data_delay_var_ram.sv
// ---------------------------------------------------------------------------
// jelly3_data_delay_var_ram
//   Ring storage for the variable delay line: DEPTH words, one synchronous
//   write port, one asynchronous read port. Each word has two parts. The
//   valid column is cleared by reset, so stale samples can never appear as
//   valid. The payload column is never reset.
//
// Ports
//   reset   async active-high, clears the valid column only
//   clk     write clock
//   we      write strobe
//   waddr   write index (always < DEPTH)
//   wvalid  valid bit to store
//   wdata   payload to store
//   raddr   read index (always < DEPTH)
//   rvalid  stored valid bit at raddr (combinational)
//   rdata   stored payload at raddr (combinational)
// ---------------------------------------------------------------------------
module jelly3_data_delay_var_ram #(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic                 wvalid,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic                 rvalid,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DEPTH-1:0]     mem_valid;
    logic [DATA_BITS-1:0] mem_data [0:DEPTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= '0;
        end else if (we) begin
            mem_valid[waddr] <= wvalid;
        end
    end

    // Payload is left unreset. Until a slot is overwritten, the output
    // mask in the parent hides it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_data[waddr] <= wdata;
        end
    end

    assign rvalid = mem_valid[raddr];
    assign rdata  = mem_data[raddr];

endmodule

// File: rtl/jelly3_data_delay_var.sv
// ---------------------------------------------------------------------------
// jelly3_data_delay_var
//   Delay line with a runtime-variable latency. On every cke cycle one sample
//   {s_valid, s_data} is written into a MAX_LATENCY-deep ring. The output is
//   read combinationally L entries behind the write pointer. L = 0 is a pure
//   combinational bypass. After a reset or a latency load, the output stays
//   masked (m_valid = 0, m_data = DATA_INIT) until L fresh samples are in.
//
// Ports
//   reset         async active-high reset
//   clk           clock, rising edge
//   cke           clock enable, advances the delay line
//   s_latency     requested latency in cke cycles (clamped to MAX_LATENCY)
//   s_latency_we  load strobe for s_latency, works regardless of cke
//   s_valid       input sample qualifier
//   s_data        input samples, CHANNELS lanes
//   m_latency     latency currently in effect
//   m_valid       output sample qualifier
//   m_data        delayed samples, CHANNELS lanes
// ---------------------------------------------------------------------------
module jelly3_data_delay_var #(
    parameter  int    MAX_LATENCY  = 16,
    parameter  int    CHANNELS     = 1,
    parameter  int    DATA_BITS    = 8,
    parameter  type   data_t       = logic [DATA_BITS-1:0],
    parameter  data_t DATA_INIT    = 'x,
    parameter  int    LATENCY_INIT = 1,
    localparam int    LAT_BITS     = $clog2(MAX_LATENCY+1)
) (
    input  logic                       reset,
    input  logic                       clk,
    input  logic                       cke,
    input  logic [LAT_BITS-1:0]        s_latency,
    input  logic                       s_latency_we,
    input  logic                       s_valid,
    input  data_t [CHANNELS-1:0]       s_data,
    output logic [LAT_BITS-1:0]        m_latency,
    output logic                       m_valid,
    output data_t [CHANNELS-1:0]       m_data
);

    localparam int PTR_BITS  = (MAX_LATENCY > 1) ? $clog2(MAX_LATENCY) : 1;
    localparam int SUM_BITS  = LAT_BITS + 1;
    localparam int WORD_BITS = CHANNELS * $bits(data_t);

    localparam logic [LAT_BITS-1:0] LAT_MAX   = LAT_BITS'(MAX_LATENCY);
    localparam logic [LAT_BITS-1:0] LAT_RESET = (LATENCY_INIT > MAX_LATENCY)
                                              ? LAT_MAX : LAT_BITS'(LATENCY_INIT);
    localparam logic [PTR_BITS-1:0] PTR_LAST  = PTR_BITS'(MAX_LATENCY - 1);
    localparam logic [SUM_BITS-1:0] SUM_DEPTH = SUM_BITS'(MAX_LATENCY);

    logic [PTR_BITS-1:0]  wr_ptr;
    logic [LAT_BITS-1:0]  fill;
    logic [LAT_BITS-1:0]  lat_clamped;
    logic [SUM_BITS-1:0]  rd_sum;
    logic [PTR_BITS-1:0]  rd_addr;
    logic                 rd_valid;
    logic [WORD_BITS-1:0] rd_word;
    logic [WORD_BITS-1:0] wr_word;
    logic                 primed;

    assign lat_clamped = (s_latency > LAT_MAX) ? LAT_MAX : s_latency;
    assign wr_word     = s_data;

    // -----------------------------------------------------------------------
    // Write pointer, fill counter, latency register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            fill      <= '0;
            m_latency <= LAT_RESET;
        end else begin
            if (cke) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            // A load restarts the fill count. The sample written on the
            // load edge (if cke) is the first one under the new latency.
            if (s_latency_we) begin
                m_latency <= lat_clamped;
                fill      <= cke ? LAT_BITS'(1) : '0;
            end else if (cke && (fill != LAT_MAX)) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read index = (wr_ptr - L) mod MAX_LATENCY. Adding the depth first
    // keeps the arithmetic non-negative. For L = MAX_LATENCY this lands on
    // wr_ptr itself, so the oldest entry is read before it is overwritten.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_sum = SUM_BITS'(wr_ptr) + SUM_DEPTH - SUM_BITS'(m_latency);
        if (rd_sum >= SUM_DEPTH) begin
            rd_sum = rd_sum - SUM_DEPTH;
        end
    end

    assign rd_addr = PTR_BITS'(rd_sum);
    assign primed  = (fill >= m_latency);

    jelly3_data_delay_var_ram #(
        .DEPTH      (MAX_LATENCY),
        .ADDR_BITS  (PTR_BITS),
        .DATA_BITS  (WORD_BITS)
    ) u_ram (
        .reset      (reset),
        .clk        (clk),
        .we         (cke),
        .waddr      (wr_ptr),
        .wvalid     (s_valid),
        .wdata      (wr_word),
        .raddr      (rd_addr),
        .rvalid     (rd_valid),
        .rdata      (rd_word)
    );

    // -----------------------------------------------------------------------
    // Output select: bypass, masked, or ring read. Reset forces m_valid low
    // on every path, including the bypass.
    // -----------------------------------------------------------------------
    always_comb begin
        m_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            m_data[i] = DATA_INIT;
        end
        if (m_latency == '0) begin
            m_valid = s_valid;
            m_data  = s_data;
        end else if (primed) begin
            m_valid = rd_valid;
            m_data  = rd_word;
        end
        if (reset) begin
            m_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_jelly3_data_delay_var.sv
module tb_jelly3_data_delay_var;

    localparam int MAXL = 16;

    logic             reset;
    logic             clk;
    logic             cke;
    logic [4:0]       s_latency;
    logic             s_latency_we;
    logic             s_valid;
    logic [1:0][7:0]  s_data;
    logic [4:0]       m_latency;
    logic             m_valid;
    logic [1:0][7:0]  m_data;

    jelly3_data_delay_var #(
        .MAX_LATENCY  (MAXL),
        .CHANNELS     (2),
        .DATA_BITS    (8),
        .DATA_INIT    (8'hA5),
        .LATENCY_INIT (3)
    ) dut (
        .reset        (reset),
        .clk          (clk),
        .cke          (cke),
        .s_latency    (s_latency),
        .s_latency_we (s_latency_we),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .m_latency    (m_latency),
        .m_valid      (m_valid),
        .m_data       (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic            v;
        logic [1:0][7:0] d;
    } ent_t;

    ent_t            sb[$];
    int              checks    = 0;
    int              failures  = 0;
    int              edge_cnt  = 0;
    int              exp_lat   = 3;
    logic            last_cke  = 1'b1;
    logic            mon_en    = 1'b0;
    logic            cur_v     = 1'b0;
    logic            cur_has_d = 1'b0;
    logic [1:0][7:0] cur_d     = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // count cke edges seen by the design
    always @(posedge clk) begin
        if (!reset) begin
            last_cke = cke;
            if (cke) edge_cnt++;
        end
    end

    // monitor: pops the expected sample due after the current cke edge
    always @(negedge clk) begin
        ent_t e;
        if (mon_en && !reset) begin
            chk("m_latency", 64'(m_latency), 64'(exp_lat));
            if (!last_cke) begin
                chk("hold_valid", 64'(m_valid), 64'(cur_v));
                if (cur_has_d) chk("hold_data", 64'(m_data), 64'(cur_d));
            end else if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                e = sb.pop_front();
                if (e.due < edge_cnt) chk("sample_due", 64'(e.due), 64'(edge_cnt));
                chk("m_valid", 64'(m_valid), 64'(e.v));
                chk("m_data", 64'(m_data), 64'(e.d));
                cur_v = e.v; cur_d = e.d; cur_has_d = 1'b1;
            end else begin
                chk("m_valid_idle", 64'(m_valid), 64'd0);
                cur_v = 1'b0; cur_has_d = 1'b0;
            end
        end
    end

    task automatic step(input logic c, input logic v, input logic [7:0] d);
        cke = c; s_valid = v; s_data[0] = d; s_data[1] = ~d;
        if (c && mon_en && exp_lat > 0)
            sb.push_back('{due: edge_cnt + exp_lat, v: v, d: {~d, d}});
        @(posedge clk); #1;
    endtask

    task automatic load(input int lat, input logic v, input logic [7:0] d);
        int nl;
        int due;
        nl  = (lat > MAXL) ? MAXL : lat;
        due = edge_cnt + nl;
        cke = 1'b1; s_latency = 5'(lat); s_latency_we = 1'b1;
        s_valid = v; s_data[0] = d; s_data[1] = ~d;
        @(posedge clk); #1;
        s_latency_we = 1'b0;
        exp_lat = nl;
        sb.delete();
        if (mon_en && nl > 0) sb.push_back('{due: due, v: v, d: {~d, d}});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        reset = 1'b1; cke = 1'b0; s_latency = '0; s_latency_we = 1'b0;
        s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_valid", 64'(m_valid), 64'd0);
        chk("reset_m_latency", 64'(m_latency), 64'd3);
        chk("reset_m_data", 64'(m_data), 64'hA5A5);
        reset = 1'b0; mon_en = 1'b1; exp_lat = 3;

        // ramp at the reset latency of 3
        for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, 8'(i));

        // full-depth latency, 40 samples wrap the ring twice, then drain
        load(16, 1'b1, 8'h40);
        for (int i = 1; i < 40; i++) step(1'b1, 1'b1, 8'(8'h40 + i));
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h00);

        // latency 4 steady, then shorten to 2 on a cke=1 edge
        load(4, 1'b1, 8'h80);
        for (int i = 1; i < 8; i++) step(1'b1, 1'b1, 8'(8'h80 + i));
        load(2, 1'b1, 8'h90);
        for (int i = 1; i < 7; i++) step(1'b1, 1'b1, 8'(8'h90 + i));

        // cke toggling at latency 2
        for (int i = 0; i < 8; i++) step((i % 2) == 0, 1'b1, 8'(8'hB0 + i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'hB8 + i));

        // oversize latency is clamped; valid pattern 1,0,1 reappears 16 later
        load(31, 1'b1, 8'hC1);
        step(1'b1, 1'b0, 8'hC2);
        step(1'b1, 1'b1, 8'hC3);
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 8'h00);

        // bypass at latency 0, then asynchronous reset
        mon_en = 1'b0;
        load(0, 1'b0, 8'h00);
        chk("bypass_m_latency", 64'(m_latency), 64'd0);
        for (int k = 0; k < 3; k++) begin
            d = 8'(8'hE0 + k * 7);
            s_valid = (k != 1); s_data[0] = d; s_data[1] = ~d;
            #1;
            chk("bypass_valid", 64'(m_valid), 64'(k != 1));
            chk("bypass_data", 64'(m_data), 64'({~d, d}));
            #2;
        end
        s_valid = 1'b1;
        #1;
        chk("bypass_valid_pre_reset", 64'(m_valid), 64'd1);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("async_reset_m_valid", 64'(m_valid), 64'd0);
        chk("async_reset_m_latency", 64'(m_latency), 64'd3);
        chk("async_reset_m_data", 64'(m_data), 64'hA5A5);
        @(posedge clk); #1;
        reset = 1'b0; exp_lat = 3; mon_en = 1'b1; cur_has_d = 1'b0; cur_v = 1'b0;

        // restart after reset: nothing valid for 3 cke cycles
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 8'(8'hD0 + i));
        repeat (4) begin
            cke = 1'b1; s_valid = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jelly3_data_delay_var.md
JELLY3_DATA_DELAY_VAR -- requirements
Module: jelly3_data_delay_var

Interface
REQ-001 SHALL have parameter MAX_LATENCY, default 16: ring depth and largest supported delay (>=1).
REQ-002 SHALL have parameter CHANNELS, default 1: number of parallel data lanes sharing one delay.
REQ-003 SHALL have parameter DATA_BITS, default 8: bits per lane.
REQ-004 SHALL have parameter type data_t, default logic [DATA_BITS-1:0]: lane payload type.
REQ-005 SHALL have parameter DATA_INIT, default 'x: m_data value while not primed.
REQ-006 SHALL have parameter LATENCY_INIT, default 1: latency after reset, clamped to MAX_LATENCY.
REQ-007 SHALL have localparam LAT_BITS = $clog2(MAX_LATENCY+1).
REQ-008 SHALL have the port list below; one clock; reset is asynchronous and active-high.
- reset  input  1  asynchronous active-high reset
- clk  input  1  clock, rising edge
- cke  input  1  clock enable, advances the delay line
- s_latency  input  LAT_BITS  requested latency in cke cycles
- s_latency_we  input  1  load strobe for s_latency
- s_valid  input  1  input sample qualifier
- s_data  input  data_t[CHANNELS]  input samples
- m_latency  output  LAT_BITS  latency currently in effect
- m_valid  output  1  output sample qualifier
- m_data  output  data_t[CHANNELS]  delayed samples

Function
REQ-009 SHALL store {s_valid, s_data} at wr_ptr on every clk edge with cke=1 and advance wr_ptr modulo MAX_LATENCY; cke=0 freezes all state except latency load.
REQ-010 SHALL, for m_latency=L>=1, present on m_data/m_valid the entry written L cke-cycles earlier, read combinationally from index (wr_ptr-L) mod MAX_LATENCY.
REQ-011 SHALL, for L=MAX_LATENCY, return the oldest entry (index wr_ptr) read before it is overwritten in the same cycle.
REQ-012 SHALL, for L=0, bypass combinationally: m_data=s_data, m_valid=s_valid; storage keeps writing.
REQ-013 SHALL keep a fill counter of cke cycles since the last reset or latency load, saturating at MAX_LATENCY.
REQ-014 SHALL define primed = (fill >= L); while not primed, m_valid=0 and m_data=DATA_INIT on all lanes.
REQ-015 SHALL, on clk edge with s_latency_we=1 (independent of cke), load m_latency <= min(s_latency, MAX_LATENCY) and set fill <= (cke ? 1 : 0).
REQ-016 SHALL, on latency load with cke=1, still write the current input sample; it counts as the first post-load sample.
REQ-017 SHALL make the new latency visible on m_latency and in read indexing in the cycle after the load edge.
REQ-018 SHALL handle wrap-around of wr_ptr and the read index with no bubble, duplicate or dropped sample at steady latency.
REQ-019 SHALL clamp s_latency values > MAX_LATENCY to MAX_LATENCY; no error output.

Reset
REQ-020 SHALL asynchronously set wr_ptr=0, fill=0, m_latency=min(LATENCY_INIT, MAX_LATENCY), all stored valid bits=0.
REQ-021 SHALL force m_valid=0 while reset is asserted, including the L=0 bypass; m_data=DATA_INIT when L>=1.
REQ-022 SHALL NOT reset stored data; primed masking guarantees DATA_INIT output until overwritten.
REQ-023 SHALL, on reset mid-stream, discard all in-flight samples; first m_valid=1 after release no earlier than L cke cycles later.

Structure
REQ-024 SHALL need no shared package; LAT_BITS and pointer widths are local derived constants.
REQ-025 SHALL place storage in one sub-module jelly3_data_delay_var_ram (MAX_LATENCY x (1+CHANNELS*bits), one write port, one asynchronous read port, valid column async-reset).
REQ-026 SHALL fit in 120-400 lines of RTL including the sub-module.

Verification
REQ-027 Reset with LATENCY_INIT=3, cke=1, ramp s_data=1,2,3... s_valid=1 -> m_valid=0 for first 3 cycles, then m_data=1,2,3... each exactly 3 cycles late.
REQ-028 MAX_LATENCY=16, load L=16, stream 40 samples -> output sample n equals input n-16 across two pointer wraps, no gaps.
REQ-029 L=4 steady, load L=2 with cke=1 -> m_valid=0 for one cycle after load, then outputs samples starting at the load-cycle sample, 2 cycles late.
REQ-030 L=0 -> m_data equals s_data same cycle; assert reset -> m_valid=0 immediately, asynchronously.
REQ-031 Toggle cke 1,0,1,0 with L=2 -> output advances only on cke=1 edges; fill unchanged on cke=0.
REQ-032 Load s_latency=31 with MAX_LATENCY=16 -> m_latency=16; s_valid pattern 1,0,1 reappears 16 cke cycles later.
